apb_cmd_master: RTL and testbench

//  Single-outstanding APB initiator. Turns a valid/ready command stream (addr, wdata, write) into APB SETUP/ACCESS

---
 rtl/apb_cmd_master_pkg.sv | 33 +++
 rtl/apb_cmd_master.sv | 185 ++++++++++++++++++
 tb/tb_apb_cmd_master.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_pkg.sv
// Shared types for the APB command master: FSM states, command/response bundles,
// default widths and timeout counter sizing helper.
package apb_cmd_master_pkg;

  localparam int unsigned APB_AW_DEF  = 12;
  localparam int unsigned APB_DW_DEF  = 32;
  localparam int unsigned TMO_DEF     = 256;
  localparam int unsigned TMO_CNT_W   = $clog2(TMO_DEF);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_AW_DEF-1:0] addr;
    logic [APB_DW_DEF-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DW_DEF-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

  // Counter width for a given cycle budget, never below one bit.
  function automatic int unsigned tmo_cnt_w(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB initiator: cmd stream (addr/wdata/write) in, APB SETUP/ACCESS
// out, rsp stream (rdata/err) back. Optional ACCESS abort under APB_CMD_MASTER_TIMEOUT_EN.
// Ports: clk_i, rst_i (sync, high); cmd_valid_i/cmd_ready_o/cmd_write_i/cmd_addr_i/
// cmd_wdata_i; rsp_valid_o/rsp_ready_i/rsp_rdata_o/rsp_err_o; paddr_o/pwdata_o/pwrite_o/
// psel_o/penable_o/prdata_i/pready_i/pslverr_i; busy_o; timeout_o.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = APB_AW_DEF,
  parameter int unsigned APB_DATA_WIDTH = APB_DW_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TMO_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i,
  output logic                      busy_o,
  output logic                      timeout_o
);

  apb_mst_state_e state_q, state_d;

  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      busy_q, busy_d;
  logic                      timeout_q, timeout_d;
  logic                      cmd_ready;
  logic                      accept;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = tmo_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Ready in IDLE, or in RESP when the response drains this cycle.
  assign cmd_ready = (state_q == IDLE) ||
                     ((state_q == RESP) && rsp_ready_i);
  assign accept    = cmd_valid_i && cmd_ready;

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timeout_d   = 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          paddr_d  = cmd_addr_i;
          pwdata_d = cmd_wdata_i;
          pwrite_d = cmd_write_i;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (pready_i) begin
          rsp_err_d   = pslverr_i;
          rsp_rdata_d = pwrite_q ? '0 : prdata_i;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          timeout_d   = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (accept) begin
            paddr_d  = cmd_addr_i;
            pwdata_d = cmd_wdata_i;
            pwrite_d = cmd_write_i;
            psel_d   = 1'b1;
            state_d  = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign cmd_ready_o = cmd_ready;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pwrite_o    = pwrite_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed timing cases plus random traffic,
// with a scoreboard of expected responses and an APB slave model.
module tb_apb_cmd_master;
  import apb_cmd_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready_o, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid_o, rsp_ready;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [11:0] paddr_o;
  logic [31:0] pwdata_o, prdata;
  logic        pwrite_o, psel_o, penable_o, pready, pslverr;
  logic        busy_o, timeout_o;

  always #5 clk = ~clk;

  apb_cmd_master #(
    .APB_ADDR_WIDTH(12),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr),
    .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
    .psel_o(psel_o), .penable_o(penable_o),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ws_cfg = 0;
  bit ws_rand = 0;
  int rdy_mode = 0;
  bit exp_tmo = 0;
  int last_acc = 0;
  int acc_cyc = 0;
  apb_rsp_t exp_q[$];
  apb_cmd_t apb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic logic [31:0] rd_model(logic [11:0] a);
    if (a == 12'h008) return 32'h1234_5678;
    return (32'(a) * 32'h0001_0003) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic err_rule(logic [11:0] a);
    return a[11:8] == 4'hE;
  endfunction

  // Slave: waits ws cycles in ACCESS, then completes. Noise on
  // pready/prdata/pslverr outside the completing ACCESS cycle.
  initial begin
    int cnt = 0;
    int ws = 0;
    apb_cmd_t c;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (psel_o && penable_o) begin
        if (cnt == 0) ws = ws_rand ? int'($urandom_range(0, 3)) : ws_cfg;
        chk("apb_pending", apb_q.size() != 0, 1);
        if (apb_q.size() != 0) begin
          c = apb_q[0];
          chk("paddr", paddr_o, c.addr);
          chk("pwrite", pwrite_o, c.write);
          if (ws >= 0 && cnt == ws) begin
            pready = 1'b1;
            prdata = rd_model(paddr_o);
            pslverr = err_rule(paddr_o);
            if (c.write) chk("pwdata", pwdata_o, c.wdata);
            last_acc = cnt + 1;
            void'(apb_q.pop_front());
            cnt = 0;
          end else begin
            pready = 1'b0;
            prdata = $urandom;
            pslverr = 1'($urandom);
            cnt++;
          end
        end
      end else begin
        pready = 1'($urandom);
        prdata = $urandom;
        pslverr = 1'($urandom);
        cnt = 0;
      end
    end
  end

  // Response monitor: every presented response must match the head
  // of the scoreboard, and stay so until consumed.
  initial begin
    apb_rsp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
      #2;
      if (rsp_valid_o) begin
        chk("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("rsp_rdata", rsp_rdata_o, e.rdata);
          chk("rsp_err", rsp_err_o, e.err);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(bit w, logic [11:0] a, logic [31:0] d);
    apb_rsp_t r;
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    forever begin
      #2;
      if (cmd_ready_o) begin
        if (exp_tmo) r = '{rdata: '0, err: 1'b1};
        else r = '{rdata: w ? 32'h0 : rd_model(a), err: err_rule(a)};
        exp_q.push_back(r);
        apb_q.push_back('{write: w, addr: a, wdata: d});
        @(posedge clk);
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
      n++;
      if (n > 2000) begin
        chk("cmd_accept_timeout", 0, 1);
        break;
      end
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 || apb_q.size() != 0 || busy_o) begin
      @(negedge clk); #3;
      n++;
      if (n > 300) begin
        chk("drain_timeout", 0, 1);
        exp_q.delete(); apb_q.delete();
        break;
      end
    end
  endtask

  task automatic rst_mid(int n);
    ws_cfg = -1;
    send(1'b0, 12'h050, 32'h0);
    repeat (n) @(negedge clk);
    #3;
    chk("still_access", penable_o & psel_o, 1);
    chk("still_no_rsp", rsp_valid_o, 0);
    chk("no_timeout", timeout_o, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #3;
    chk("rst_psel", psel_o, 0);
    chk("rst_penable", penable_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    exp_q.delete(); apb_q.delete();
    @(negedge clk); rst = 1'b0;
    ws_cfg = 0;
    repeat (3) @(negedge clk);
    #3 chk("post_rst_no_rsp", rsp_valid_o, 0);
    send(1'b1, 12'h060, 32'hCAFE_0060);
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[$];
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_psel", psel_o, 0);
    chk("reset_penable", penable_o, 0);
    chk("reset_pwrite", pwrite_o, 0);
    chk("reset_rsp_valid", rsp_valid_o, 0);
    chk("reset_rsp_err", rsp_err_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_timeout", timeout_o, 0);
    chk("reset_paddr", paddr_o, 0);
    chk("reset_pwdata", pwdata_o, 0);
    chk("reset_rdata", rsp_rdata_o, 0);
    rst = 1'b0;

    // Zero-wait write: SETUP N+1, ACCESS N+2, rsp N+3.
    ws_cfg = 0; rdy_mode = 0;
    send(1'b1, 12'h004, 32'hA5A5_0001);
    @(negedge clk); #1;
    chk("n1_psel", psel_o, 1);
    chk("n1_penable", penable_o, 0);
    chk("n1_busy", busy_o, 1);
    @(negedge clk); #1;
    chk("n2_penable", penable_o, 1);
    chk("n2_rsp_valid", rsp_valid_o, 0);
    @(negedge clk); #1;
    chk("n3_rsp_valid", rsp_valid_o, 1);
    chk("n3_psel", psel_o, 0);
    wait_idle();

    // Read with 3 wait states.
    ws_cfg = 3;
    send(1'b0, 12'h008, 32'h0);
    wait_idle();
    chk("access_len", last_acc, 4);

    // Error read, then a clean write.
    ws_cfg = 1;
    send(1'b0, 12'hE10, 32'h0);
    send(1'b1, 12'h020, 32'h0000_BEEF);
    wait_idle();

    // Back-to-back writes, one accept every 3 cycles.
    ws_cfg = 0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 12'(12'h100 + 4 * i), 32'(32'h1000 + i));
      acc.push_back(acc_cyc);
    end
    wait_idle();
    for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], 3);

    // Response backpressure.
    rdy_mode = 2;
    send(1'b0, 12'h030, 32'h0);
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      @(negedge clk); #3; n++;
    end
    chk("bp_rsp_seen", rsp_valid_o, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #3;
      chk("bp_cmd_ready", cmd_ready_o, 0);
      chk("bp_rsp_held", rsp_valid_o, 1);
    end
    rdy_mode = 0;
    wait_idle();

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    ws_cfg = -1; exp_tmo = 1;
    send(1'b0, 12'h040, 32'h0);
    exp_tmo = 0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #3;
      if (penable_o) n++;
      if (rsp_valid_o) break;
    end
    chk("tmo_access_len", n, 8);
    chk("tmo_pulse", timeout_o, 1);
    @(negedge clk); #3;
    chk("tmo_pulse_end", timeout_o, 0);
    void'(apb_q.pop_front());
    ws_cfg = 0;
    wait_idle();
    rst_mid(3);
`else
    rst_mid(1000);
`endif

    // Random traffic with random waits and backpressure.
    ws_rand = 1; rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom), 12'($urandom), $urandom);
    end
    wait_idle();
    ws_rand = 0; rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
